// File: rtl/dtc_stream_sched.sv
// Streaming classifier scheduler: registers feature vectors into an external
// combinational classifier, emits per-sample classes and a per-batch majority vote.
//
// state | meaning
// IDLE  | waiting to accept a feature vector
// EVAL  | capture classifier result, update vote counters
// VOTE  | compute batch majority (last sample only)
// EMIT  | offer result until the consumer accepts it
module dtc_stream_sched #(
  parameter int FEAT_W = 12,
  parameter int CLS_W  = 3,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FEAT_W-1:0] in_feat,
  input  logic [CNT_W-1:0]  batch_len,
  input  logic              flush,
  output logic [FEAT_W-1:0] cls_inp,
  input  logic [CLS_W-1:0]  cls_outp,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CLS_W-1:0]  out_class,
  output logic              out_last,
  output logic [CLS_W-1:0]  out_vote
);

  localparam int NCLS = 1 << CLS_W;

  typedef enum logic [1:0] {IDLE, EVAL, VOTE, EMIT} state_t;

  state_t             state, state_nx;
  logic [FEAT_W-1:0]  feat_q;
  logic [CLS_W-1:0]   res_q;
  logic [CLS_W-1:0]   vote_q;
  logic [CLS_W-1:0]   vote_win;
  logic [CNT_W-1:0]   vote_best;
  logic               last_q;
  logic               flush_pend;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   len_q;
  logic [CNT_W-1:0]   vote_cnt [NCLS];
  logic               accept;
  logic               done;
  logic               last_nx;

  assign in_ready  = !rst && (state == IDLE);
  assign out_valid = !rst && (state == EMIT);
  assign accept    = in_valid && in_ready;
  assign done      = out_valid && out_ready;
  assign last_nx   = (({1'b0, cnt} + (CNT_W+1)'(1)) == {1'b0, len_q}) || flush_pend;

  assign cls_inp   = rst ? '0 : feat_q;
  assign out_class = rst ? '0 : res_q;
  assign out_last  = rst ? 1'b0 : last_q;
  assign out_vote  = (rst || !last_q) ? '0 : vote_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = EVAL;
      EVAL: state_nx = last_nx ? VOTE : EMIT;
      VOTE: state_nx = EMIT;
      EMIT: if (done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Strict '>' keeps the lowest class index on ties.
  always_comb begin
    vote_win  = '0;
    vote_best = '0;
    for (int i = 0; i < NCLS; i++) begin
      if (vote_cnt[i] > vote_best) begin
        vote_best = vote_cnt[i];
        vote_win  = CLS_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      feat_q     <= '0;
      res_q      <= '0;
      vote_q     <= '0;
      last_q     <= 1'b0;
      cnt        <= '0;
      len_q      <= '0;
      flush_pend <= 1'b0;
      for (int i = 0; i < NCLS; i++) vote_cnt[i] <= '0;
    end else begin
      if (accept) begin
        feat_q <= in_feat;
        if (cnt == '0) len_q <= (batch_len == '0) ? CNT_W'(1) : batch_len;
      end

      if (state == EVAL) begin
        res_q              <= cls_outp;
        vote_cnt[cls_outp] <= vote_cnt[cls_outp] + CNT_W'(1);
        cnt                <= cnt + CNT_W'(1);
        last_q             <= last_nx;
      end

      if (state == VOTE) vote_q <= vote_win;

      // Closing a batch wins over a flush arriving in the same cycle.
      if (done && last_q) begin
        cnt        <= '0;
        flush_pend <= 1'b0;
        for (int i = 0; i < NCLS; i++) vote_cnt[i] <= '0;
      end else if (flush && (state != IDLE || cnt != '0 || accept)) begin
        flush_pend <= 1'b1;
      end
    end
  end

endmodule
